issue_scheduler: RTL and testbench

Out-of-order issue scheduler between the reservation-station entry buffer and the execution units. Each cycle it picks the oldest ready entry for each unit class (ALU, BRANCH, memory), issues it through registered outputs, and masks out just-issued entries until the buffer has updated their state. It also sequences the single shared memory port through a req/ack handshake and handles pipeline flushes, including draining a memory operation already in flight.

---
 rtl/issue_scheduler_if.sv | 42 ++++
 rtl/issue_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_issue_scheduler.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/issue_scheduler_if.sv
// Issue-scheduler bundle: buffer-side entry status in, per-class issue strobes and the memory port out.
// Carries no state; all timing is defined by the scheduler that drives the "master" side.
// No backpressure on issue strobes; the memory port completes on any cycle with mem_req & mem_ack.
//
// Ports: ready/unit/tag/flush/mem_ack flow into the scheduler; the alu_*, br_*, issued_onehot,
// mem_req/mem_index/mem_kill and mem_done/mem_done_index signals flow out of it.
interface issue_scheduler_if #(
  parameter int BUF_SIZE     = 16,
  parameter int BUF_SIZE_LOG = 4
);
  logic [BUF_SIZE-1:0]                   ready;
  logic [BUF_SIZE-1:0][1:0]              unit;
  logic [BUF_SIZE-1:0][BUF_SIZE_LOG:0]   tag;
  logic                                  flush;

  logic                                  alu_issue;
  logic [BUF_SIZE_LOG-1:0]               alu_index;
  logic                                  br_issue;
  logic [BUF_SIZE_LOG-1:0]               br_index;
  logic [BUF_SIZE-1:0]                   issued_onehot;

  logic                                  mem_req;
  logic [BUF_SIZE_LOG-1:0]               mem_index;
  logic                                  mem_kill;
  logic                                  mem_ack;
  logic                                  mem_done;
  logic [BUF_SIZE_LOG-1:0]               mem_done_index;

  // Scheduler side.
  modport master (
    input  ready, unit, tag, flush, mem_ack,
    output alu_issue, alu_index, br_issue, br_index, issued_onehot,
           mem_req, mem_index, mem_kill, mem_done, mem_done_index
  );

  // Entry buffer / execution / memory side.
  modport slave (
    output ready, unit, tag, flush, mem_ack,
    input  alu_issue, alu_index, br_issue, br_index, issued_onehot,
           mem_req, mem_index, mem_kill, mem_done, mem_done_index
  );
endinterface

// File: rtl/issue_scheduler.sv
// Out-of-order issue scheduler: oldest-ready pick per class (ALU, BRANCH, memory) plus memory-port FSM.
// Latency: one cycle, inputs sampled at edge N drive registered outputs from N+1.
// Backpressure: ALU/BRANCH never stall; memory holds mem_req until mem_ack, one op per ack.
//
// Ports: clk, rst_n (async active-low); bus (issue_scheduler_if.master) carries entry status in
// and issue strobes, issued_onehot and the memory req/ack/kill/done signals out.
module issue_scheduler #(
  parameter int BUF_SIZE     = 16,
  parameter int BUF_SIZE_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  issue_scheduler_if.master    bus
);

  localparam logic [1:0] U_ALU = 2'd0;
  localparam logic [1:0] U_BR  = 2'd1;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_BUSY  = 2'd1,
    MEM_DRAIN = 2'd2
  } mem_state_e;

  mem_state_e state_q, state_d;

  logic                    alu_issue_q, alu_issue_d;
  logic [BUF_SIZE_LOG-1:0] alu_index_q, alu_index_d;
  logic                    br_issue_q, br_issue_d;
  logic [BUF_SIZE_LOG-1:0] br_index_q, br_index_d;
  // skip_q is the issued_onehot currently on the bus; it masks entries whose
  // buffer state has not caught up with the issue yet.
  logic [BUF_SIZE-1:0]     skip_q, skip_d;
  logic                    mem_req_q, mem_req_d;
  logic [BUF_SIZE_LOG-1:0] mem_index_q, mem_index_d;
  logic                    mem_kill_q, mem_kill_d;
  logic                    mem_done_q, mem_done_d;
  logic [BUF_SIZE_LOG-1:0] mem_done_index_q, mem_done_index_d;

  logic [BUF_SIZE-1:0]     cand;
  logic                    alu_found, br_found, mem_found;
  logic [BUF_SIZE_LOG-1:0] alu_win, br_win, mem_win;
  logic [BUF_SIZE_LOG:0]   alu_tag, br_tag, mem_tag;
  logic                    mem_issue;

  assign cand = bus.ready & ~skip_q;

  // Oldest-first selection. Scanning upward with a strict '>' keeps the
  // lowest index on a tag tie.
  always_comb begin
    alu_found = 1'b0; alu_win = '0; alu_tag = '0;
    br_found  = 1'b0; br_win  = '0; br_tag  = '0;
    mem_found = 1'b0; mem_win = '0; mem_tag = '0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (cand[i]) begin
        if (bus.unit[i] == U_ALU) begin
          if (!alu_found || bus.tag[i] > alu_tag) begin
            alu_found = 1'b1;
            alu_win   = BUF_SIZE_LOG'(i);
            alu_tag   = bus.tag[i];
          end
        end else if (bus.unit[i] == U_BR) begin
          if (!br_found || bus.tag[i] > br_tag) begin
            br_found = 1'b1;
            br_win   = BUF_SIZE_LOG'(i);
            br_tag   = bus.tag[i];
          end
        end else begin
          // LOAD and STORE share the memory class.
          if (!mem_found || bus.tag[i] > mem_tag) begin
            mem_found = 1'b1;
            mem_win   = BUF_SIZE_LOG'(i);
            mem_tag   = bus.tag[i];
          end
        end
      end
    end
  end

  // Memory FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: begin
        if (mem_found && !bus.flush) state_d = MEM_BUSY;
      end
      MEM_BUSY: begin
        if (bus.flush)        state_d = bus.mem_ack ? MEM_IDLE : MEM_DRAIN;
        else if (bus.mem_ack) state_d = mem_found ? MEM_BUSY : MEM_IDLE;
      end
      MEM_DRAIN: begin
        if (bus.mem_ack) state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // Memory FSM: registered port outputs.
  always_comb begin
    mem_req_d        = 1'b0;
    mem_index_d      = mem_index_q;
    mem_kill_d       = 1'b0;
    mem_done_d       = 1'b0;
    mem_done_index_d = mem_done_index_q;
    mem_issue        = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (mem_found && !bus.flush) begin
          mem_req_d   = 1'b1;
          mem_index_d = mem_win;
          mem_issue   = 1'b1;
        end
      end
      MEM_BUSY: begin
        if (bus.flush) begin
          // Flush with a simultaneous ack simply drops the result.
          if (!bus.mem_ack) begin
            mem_req_d  = 1'b1;
            mem_kill_d = 1'b1;
          end
        end else if (bus.mem_ack) begin
          mem_done_d       = 1'b1;
          mem_done_index_d = mem_index_q;
          if (mem_found) begin
            mem_req_d   = 1'b1;
            mem_index_d = mem_win;
            mem_issue   = 1'b1;
          end
        end else begin
          mem_req_d = 1'b1;
        end
      end
      MEM_DRAIN: begin
        if (!bus.mem_ack) begin
          mem_req_d  = 1'b1;
          mem_kill_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ALU/BRANCH strobes and the issued mask.
  always_comb begin
    alu_issue_d = alu_found & ~bus.flush;
    alu_index_d = alu_found ? alu_win : alu_index_q;
    br_issue_d  = br_found & ~bus.flush;
    br_index_d  = br_found ? br_win : br_index_q;
    skip_d      = '0;
    if (!bus.flush) begin
      if (alu_found) skip_d[alu_win] = 1'b1;
      if (br_found)  skip_d[br_win]  = 1'b1;
      if (mem_issue) skip_d[mem_win] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= MEM_IDLE;
      alu_issue_q      <= 1'b0;
      alu_index_q      <= '0;
      br_issue_q       <= 1'b0;
      br_index_q       <= '0;
      skip_q           <= '0;
      mem_req_q        <= 1'b0;
      mem_index_q      <= '0;
      mem_kill_q       <= 1'b0;
      mem_done_q       <= 1'b0;
      mem_done_index_q <= '0;
    end else begin
      state_q          <= state_d;
      alu_issue_q      <= alu_issue_d;
      alu_index_q      <= alu_index_d;
      br_issue_q       <= br_issue_d;
      br_index_q       <= br_index_d;
      skip_q           <= skip_d;
      mem_req_q        <= mem_req_d;
      mem_index_q      <= mem_index_d;
      mem_kill_q       <= mem_kill_d;
      mem_done_q       <= mem_done_d;
      mem_done_index_q <= mem_done_index_d;
    end
  end

  assign bus.alu_issue      = alu_issue_q;
  assign bus.alu_index      = alu_index_q;
  assign bus.br_issue       = br_issue_q;
  assign bus.br_index       = br_index_q;
  assign bus.issued_onehot  = skip_q;
  assign bus.mem_req        = mem_req_q;
  assign bus.mem_index      = mem_index_q;
  assign bus.mem_kill       = mem_kill_q;
  assign bus.mem_done       = mem_done_q;
  assign bus.mem_done_index = mem_done_index_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed vectors, expected issues/completions queued at stimulus time
// and popped by a negedge monitor; a small buffer model clears ready one edge after issued_onehot.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_issue_scheduler;
  localparam int N = 16;
  localparam int L = 4;
  localparam logic [1:0] U_ALU = 2'd0;
  localparam logic [1:0] U_BR  = 2'd1;
  localparam logic [1:0] U_LD  = 2'd2;
  localparam logic [1:0] U_ST  = 2'd3;

  logic clk;
  logic rst_n;

  issue_scheduler_if #(.BUF_SIZE(N), .BUF_SIZE_LOG(L)) bus();

  issue_scheduler #(.BUF_SIZE(N), .BUF_SIZE_LOG(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int alu_q[$];
  int br_q[$];
  int mem_q[$];
  int done_q[$];
  logic [N-1:0] pend;
  logic prev_req;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_all();
    bus.ready   = '0;
    bus.unit    = '0;
    bus.tag     = '0;
    bus.flush   = 1'b0;
    bus.mem_ack = 1'b0;
  endtask

  task automatic set_ent(input int idx, input logic [1:0] u, input int t);
    bus.unit[idx]  = u;
    bus.tag[idx]   = 5'(t);
    bus.ready[idx] = 1'b1;
  endtask

  // One clock. The buffer model retires entries reported in issued_onehot
  // at the edge after they were reported.
  task automatic step();
    @(posedge clk);
    #1;
    bus.ready = bus.ready & ~pend;
    @(negedge clk);
    pend = bus.issued_onehot;
  endtask

  // Scoreboard monitor: every issue/completion the DUT presents must match
  // the next queued expectation; one with nothing queued is a failure.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (bus.alu_issue) begin
        if (alu_q.size() == 0) chk("alu_unexpected", int'(bus.alu_index), -1);
        else chk("alu_index", int'(bus.alu_index), alu_q.pop_front());
      end
      if (bus.br_issue) begin
        if (br_q.size() == 0) chk("br_unexpected", int'(bus.br_index), -1);
        else chk("br_index", int'(bus.br_index), br_q.pop_front());
      end
      if (bus.mem_req && !bus.mem_kill && (!prev_req || bus.mem_done)) begin
        if (mem_q.size() == 0) chk("mem_unexpected", int'(bus.mem_index), -1);
        else chk("mem_index", int'(bus.mem_index), mem_q.pop_front());
      end
      if (bus.mem_done) begin
        if (done_q.size() == 0) chk("done_unexpected", int'(bus.mem_done_index), -1);
        else chk("mem_done_index", int'(bus.mem_done_index), done_q.pop_front());
      end
      prev_req = bus.mem_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    clear_all();
    pend = '0;
    #3 rst_n = 1'b0;
    #10;
    chk("rst_alu_issue", int'(bus.alu_issue), 0);
    chk("rst_br_issue",  int'(bus.br_issue), 0);
    chk("rst_onehot",    int'(bus.issued_onehot), 0);
    chk("rst_mem_req",   int'(bus.mem_req), 0);
    chk("rst_mem_kill",  int'(bus.mem_kill), 0);
    chk("rst_mem_done",  int'(bus.mem_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); step();

    // 1: oldest-first ALU, tie to lowest index, skip masks the just-issued entry.
    set_ent(2, U_ALU, 8); set_ent(5, U_ALU, 12); set_ent(9, U_ALU, 12);
    alu_q.push_back(5); alu_q.push_back(9); alu_q.push_back(2);
    step();
    chk("t1_alu_issue", int'(bus.alu_issue), 1);
    chk("t1_onehot_5",  int'(bus.issued_onehot), 32'h0020);
    step();
    chk("t1_onehot_9",  int'(bus.issued_onehot), 32'h0200);
    step();
    chk("t1_onehot_2",  int'(bus.issued_onehot), 32'h0004);
    step();
    chk("t1_idle_alu",  int'(bus.alu_issue), 0);
    chk("t1_idle_oh",   int'(bus.issued_onehot), 0);
    clear_all(); step(); step();

    // 2: ALU, BRANCH and LOAD issue together.
    set_ent(1, U_ALU, 10); set_ent(3, U_BR, 11); set_ent(7, U_LD, 9);
    alu_q.push_back(1); br_q.push_back(3); mem_q.push_back(7);
    step();
    chk("t2_onehot",    int'(bus.issued_onehot), 32'h008A);
    chk("t2_alu_issue", int'(bus.alu_issue), 1);
    chk("t2_br_issue",  int'(bus.br_issue), 1);
    chk("t2_mem_req",   int'(bus.mem_req), 1);
    bus.mem_ack = 1'b1; done_q.push_back(7);
    step();
    chk("t2_mem_done",  int'(bus.mem_done), 1);
    chk("t2_req_low",   int'(bus.mem_req), 0);
    clear_all(); step(); step();

    // 3: back-to-back memory ops, ack on the third BUSY cycle then held.
    set_ent(4, U_ST, 15); set_ent(6, U_LD, 14);
    mem_q.push_back(4);
    step();
    chk("t3_req_rise",  int'(bus.mem_req), 1);
    chk("t3_onehot",    int'(bus.issued_onehot), 32'h0010);
    step();
    step();
    chk("t3_req_held",  int'(bus.mem_req), 1);
    bus.mem_ack = 1'b1; done_q.push_back(4); mem_q.push_back(6);
    step();
    chk("t3_b2b_req",   int'(bus.mem_req), 1);
    chk("t3_b2b_done",  int'(bus.mem_done), 1);
    done_q.push_back(6);
    step();
    chk("t3_done_6",    int'(bus.mem_done), 1);
    chk("t3_req_low",   int'(bus.mem_req), 0);
    clear_all(); step(); step();

    // 4: flush one cycle into BUSY, ack two cycles later.
    set_ent(4, U_LD, 15);
    mem_q.push_back(4);
    step();
    bus.flush = 1'b1; set_ent(0, U_ALU, 3); set_ent(2, U_BR, 5);
    step();
    chk("t4_kill",      int'(bus.mem_kill), 1);
    chk("t4_req",       int'(bus.mem_req), 1);
    chk("t4_alu_off",   int'(bus.alu_issue), 0);
    chk("t4_br_off",    int'(bus.br_issue), 0);
    chk("t4_onehot",    int'(bus.issued_onehot), 0);
    bus.flush = 1'b0; bus.ready[0] = 1'b0; bus.ready[2] = 1'b0;
    step();
    chk("t4_kill_held", int'(bus.mem_kill), 1);
    bus.mem_ack = 1'b1;
    step();
    chk("t4_req_low",   int'(bus.mem_req), 0);
    chk("t4_kill_low",  int'(bus.mem_kill), 0);
    chk("t4_no_done",   int'(bus.mem_done), 0);
    clear_all(); step(); step();

    // 5: flush coinciding with ack goes straight to IDLE.
    set_ent(4, U_LD, 15);
    mem_q.push_back(4);
    step();
    bus.flush = 1'b1; bus.mem_ack = 1'b1;
    step();
    chk("t5_req_low",   int'(bus.mem_req), 0);
    chk("t5_no_kill",   int'(bus.mem_kill), 0);
    chk("t5_no_done",   int'(bus.mem_done), 0);
    bus.flush = 1'b0; bus.mem_ack = 1'b0;
    step();
    chk("t5_idle_req",  int'(bus.mem_req), 0);
    chk("t5_idle_kill", int'(bus.mem_kill), 0);
    clear_all(); step(); step();

    // 6: asynchronous reset while draining.
    set_ent(4, U_LD, 15);
    mem_q.push_back(4);
    step();
    bus.flush = 1'b1;
    step();
    chk("t6_drain_kill", int'(bus.mem_kill), 1);
    bus.flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_req",   int'(bus.mem_req), 0);
    chk("t6_rst_kill",  int'(bus.mem_kill), 0);
    chk("t6_rst_done",  int'(bus.mem_done), 0);
    chk("t6_rst_oh",    int'(bus.issued_onehot), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pend = '0;
    set_ent(8, U_LD, 7);
    mem_q.push_back(8);
    step();
    chk("t6_req_after", int'(bus.mem_req), 1);
    chk("t6_oh_after",  int'(bus.issued_onehot), 32'h0100);
    bus.mem_ack = 1'b1; done_q.push_back(8);
    step();
    bus.mem_ack = 1'b0;
    step(); step();

    chk("left_alu",  alu_q.size(), 0);
    chk("left_br",   br_q.size(), 0);
    chk("left_mem",  mem_q.size(), 0);
    chk("left_done", done_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
